fetch_ctrl: RTL
===============

Name: fetch_ctrl

Overview:
Instruction-fetch controller for the multi-cycle NPC core, directly upstream of the IFU memory stage.
- Owns the PC.
- Issues one AXI-lite read (AR/R channels) per instruction to IFU.
- Latches the returned word and presents it to IDU on a valid/ready interface.
- Accepts the next PC from WBU before starting the following fetch.
- Exactly one transaction is outstanding at any time.

Parameters:
RESET_PC, 32'h8000_0000, PC loaded on reset.
CNT_W, 32, width of the retired-fetch performance counter.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
araddr  output  32  read address to IFU, equals pc
arvalid  output  1  read-address valid to IFU
arready  input  1  read-address ready from IFU
rdata  input  32  read data from IFU
rresp  input  1  read response, 1 = bus error
rvalid  input  1  read-data valid from IFU
rready  output  1  read-data ready to IFU
inst  output  32  fetched instruction to IDU
inst_pc  output  32  PC of inst
inst_fault  output  2  00 none, 01 bus error, 10 misaligned PC
inst_valid  output  1  inst/inst_pc/inst_fault valid to IDU
inst_ready  input  1  IDU accepts instruction
npc  input  32  next PC from WBU
npc_valid  input  1  npc valid
npc_ready  output  1  controller accepts npc
fetch_cnt  output  CNT_W  number of completed R handshakes

Behaviour:
- Reset is asynchronous and active-high: rst asserts the state regardless of clk.
- Reset values:
  - state=S_IDLE, pc=RESET_PC, inst=0, inst_fault=00, fetch_cnt=0.
  - arvalid=0, rready=0, inst_valid=0, npc_ready=0.
- All handshake outputs decode from the state register (Moore); no combinational path from any input to any output.
- araddr=pc at all times.
- States:
  - S_IDLE: all valids/readies 0. Next cycle unconditionally -> S_AR. First arvalid is therefore seen one cycle after rst deasserts.
  - S_AR: arvalid=1, araddr stable. When arvalid&arready is sampled at a posedge -> S_R. arvalid must not drop before the handshake.
  - S_R: rready=1. On rvalid&rready:
    - inst<=rdata; inst_pc<=pc.
    - inst_fault<= rresp ? 01 : 00.
    - fetch_cnt<=fetch_cnt+1, wrapping modulo 2^CNT_W.
    - -> S_OUT.
    - rdata is ignored on error, but still latched.
  - S_OUT: inst_valid=1; inst, inst_pc and inst_fault held stable. On inst_ready -> S_WAIT. inst_ready arriving in the same cycle inst_valid first rises completes the transfer in that cycle.
  - S_WAIT: npc_ready=1. On npc_valid: pc<=npc.
    - npc[1:0]==00 -> S_AR.
    - npc[1:0]!=00 -> no bus request; inst<=0, inst_pc<=npc, inst_fault<=10, -> S_OUT. fetch_cnt is unchanged.
- Signals ignored per state:
  - arready outside S_AR.
  - rvalid outside S_R.
  - inst_ready outside S_OUT.
  - npc_valid outside S_WAIT.
- IFU inserts random delays on both valid and ready. Correctness must not depend on any fixed latency; arready or rvalid may arrive after 0..255+ cycles.
- Reset mid-transaction (S_AR or S_R): return immediately to reset values. No handshake may be counted. The in-flight response is dropped; IFU is reset by the same rst.
- Unused encodings of the state register recover to S_IDLE.

Test Plan:
1. Reset release with rst=1 for 3 cycles, then 0 -> arvalid=0 for 1 cycle after release, then arvalid=1 with araddr=0x8000_0000.
2. Normal fetch:
   - Stimulus: IFU returns rdata=0x0000_0413, rresp=0 after random delay; inst_ready=1.
   - Required: inst_valid pulses with inst=0x0000_0413, inst_pc=0x8000_0000, inst_fault=00, fetch_cnt=1, then npc_ready=1.
   - Follow-up: drive npc=0x8000_0004 -> next araddr=0x8000_0004.
3. Bus error: rresp=1, rdata=0xDEAD_BEEF -> inst_fault=01, inst_valid=1, fetch_cnt increments.
4. Misaligned redirect: in S_WAIT drive npc=0x8000_0006 -> arvalid stays 0; inst_valid=1, inst_pc=0x8000_0006, inst_fault=10, fetch_cnt unchanged.
5. Backpressure:
   - Hold inst_ready=0 for 10 cycles -> inst, inst_pc and inst_fault stable, inst_valid=1 throughout.
   - Hold npc_valid=0 for 5 cycles in S_WAIT -> arvalid stays 0.
6. Reset mid-transaction: assert rst while arvalid=1 and arready=0 -> arvalid drops asynchronously, pc=0x8000_0000, fetch_cnt=0; after release the fetch restarts from RESET_PC.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, issues one AXI-lite read per
// instruction, hands the word to IDU and waits for the next PC from WBU.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter int          CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   output logic [31:0]      araddr,
   output logic             arvalid,
   input  logic             arready,
   input  logic [31:0]      rdata,
   input  logic             rresp,
   input  logic             rvalid,
   output logic             rready,
   output logic [31:0]      inst,
   output logic [31:0]      inst_pc,
   output logic [1:0]       inst_fault,
   output logic             inst_valid,
   input  logic             inst_ready,
   input  logic [31:0]      npc,
   input  logic             npc_valid,
   output logic             npc_ready,
   output logic [CNT_W-1:0] fetch_cnt
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_AR   = 3'd1,
      S_R    = 3'd2,
      S_OUT  = 3'd3,
      S_WAIT = 3'd4
   } state_t;

   localparam logic [1:0] FAULT_NONE  = 2'b00;
   localparam logic [1:0] FAULT_BUS   = 2'b01;
   localparam logic [1:0] FAULT_ALIGN = 2'b10;

   state_t           state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic [31:0]      inst_q, inst_d;
   logic [31:0]      inst_pc_q, inst_pc_d;
   logic [1:0]       fault_q, fault_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      inst_d    = inst_q;
      inst_pc_d = inst_pc_q;
      fault_d   = fault_q;
      cnt_d     = cnt_q;
      case (state_q)
         S_IDLE: state_d = S_AR;
         S_AR: begin
            if (arready) state_d = S_R;
         end
         S_R: begin
            // The word is latched even on a bus error; IDU keys off inst_fault.
            if (rvalid) begin
               inst_d    = rdata;
               inst_pc_d = pc_q;
               fault_d   = rresp ? FAULT_BUS : FAULT_NONE;
               cnt_d     = cnt_q + CNT_W'(1);
               state_d   = S_OUT;
            end
         end
         S_OUT: begin
            if (inst_ready) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (npc_valid) begin
               pc_d = npc;
               if (npc[1:0] == 2'b00) begin
                  state_d = S_AR;
               end else begin
                  // Misaligned target: report it without touching the bus.
                  inst_d    = 32'h0;
                  inst_pc_d = npc;
                  fault_d   = FAULT_ALIGN;
                  state_d   = S_OUT;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         pc_q      <= RESET_PC;
         inst_q    <= 32'h0;
         inst_pc_q <= 32'h0;
         fault_q   <= FAULT_NONE;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         inst_q    <= inst_d;
         inst_pc_q <= inst_pc_d;
         fault_q   <= fault_d;
         cnt_q     <= cnt_d;
      end
   end

   // Handshake outputs are pure decodes of the state register.
   assign arvalid    = (state_q == S_AR);
   assign rready     = (state_q == S_R);
   assign inst_valid = (state_q == S_OUT);
   assign npc_ready  = (state_q == S_WAIT);

   assign araddr     = pc_q;
   assign inst       = inst_q;
   assign inst_pc    = inst_pc_q;
   assign inst_fault = fault_q;
   assign fetch_cnt  = cnt_q;

endmodule
